rx_packet_scheduler: RTL

- Round-robin scheduler that shares the single Ethernet packet-sender path between NR per-receiver byte FIFOs (each fed by the 48-to-8-bit Rx FIFO controllers).
- When a receiver FIFO holds a full packet payload and the sender is ready, the block grants that receiver and reads exactly PKT_BYTES bytes out of its FIFO.
- For each packet it presents a start pulse, the receiver index and a per-receiver 32-bit sequence number, followed by the byte stream.

---
 rtl/rx_packet_scheduler.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/rx_packet_scheduler.sv
// Round-robin scheduler draining per-receiver byte FIFOs into one packet sender.
// Each grant reads a full packet payload and tags it with a per-receiver sequence.
module rx_packet_scheduler #(
  parameter int NR        = 7,
  parameter int PKT_BYTES = 1440,
  parameter int CNT_W     = 13
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [NR-1:0]          rx_enable,
  input  logic [CNT_W-1:0]       fifo_used [NR],
  input  logic [7:0]             fifo_q    [NR],
  output logic [NR-1:0]          fifo_rdreq,
  input  logic                   phy_ready,
  output logic                   pkt_start,
  output logic [$clog2(NR)-1:0]  pkt_rx,
  output logic [31:0]            pkt_seq,
  output logic [7:0]             byte_out,
  output logic                   byte_valid,
  output logic                   byte_last,
  output logic                   pkt_busy
);

  localparam int RX_W = $clog2(NR);
  localparam int BC_W = $clog2(PKT_BYTES);

  typedef enum logic [2:0] {
    S_IDLE, S_ARB, S_START, S_READ, S_DRAIN
  } state_t;

  state_t            state_q, state_d;
  logic [NR-1:0]     req;
  logic [RX_W-1:0]   gnt;
  logic              gnt_found;
  logic              arb_take;
  logic              rd_en;
  logic              cnt_last;
  logic [31:0]       seq_all [NR];
  logic [RX_W-1:0]   last_grant_q, last_grant_d;
  logic [RX_W-1:0]   pkt_rx_q, pkt_rx_d;
  logic [31:0]       pkt_seq_q, pkt_seq_d;
  logic [BC_W-1:0]   cnt_q, cnt_d;
  logic              drain_q, drain_d;
  logic              v1_q, v1_d;
  logic              l1_q, l1_d;
  logic              bv_q, bv_d;
  logic              bl_q, bl_d;
  logic [7:0]        bo_q, bo_d;

  for (genvar g = 0; g < NR; g++) begin : g_rx
    logic [31:0] seq_q, seq_d;
    assign req[g] = rx_enable[g] &&
      (fifo_used[g] >= CNT_W'(PKT_BYTES));
    assign seq_all[g] = seq_q;
    // A disabled receiver restarts its stream at zero.
    always_comb begin
      seq_d = seq_q;
      if (!rx_enable[g])
        seq_d = '0;
      else if (arb_take && gnt == RX_W'(g))
        seq_d = seq_q + 32'd1;
    end
    always_ff @(posedge clock) begin
      if (reset) seq_q <= '0;
      else       seq_q <= seq_d;
    end
  end

  // Search starts just after the previous winner.
  always_comb begin
    gnt       = '0;
    gnt_found = 1'b0;
    for (int k = 1; k <= NR; k++) begin
      int s;
      s = int'(last_grant_q) + k;
      if (s >= NR) s = s - NR;
      if (!gnt_found && req[RX_W'(s)]) begin
        gnt       = RX_W'(s);
        gnt_found = 1'b1;
      end
    end
  end

  assign arb_take = (state_q == S_ARB) && gnt_found;
  assign cnt_last = (cnt_q == BC_W'(PKT_BYTES - 1));

  always_ff @(posedge clock) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (phy_ready && |req) state_d = S_ARB;
      S_ARB:   state_d = gnt_found ? S_START : S_IDLE;
      S_START: state_d = S_READ;
      S_READ:  if (cnt_last) state_d = S_DRAIN;
      S_DRAIN: if (drain_q) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Read strobe drops in the very cycle reset is applied.
  always_comb begin
    pkt_start  = (state_q == S_START);
    pkt_busy   = (state_q != S_IDLE);
    rd_en      = (state_q == S_READ) && !reset;
    fifo_rdreq = '0;
    if (rd_en)
      fifo_rdreq = {{(NR-1){1'b0}}, 1'b1} << pkt_rx_q;
  end

  always_comb begin
    cnt_d = cnt_q;
    if (state_q == S_START)
      cnt_d = '0;
    else if (state_q == S_READ)
      cnt_d = cnt_q + BC_W'(1);
    drain_d      = (state_q == S_DRAIN) ? !drain_q : 1'b0;
    last_grant_d = arb_take ? gnt : last_grant_q;
    pkt_rx_d     = arb_take ? gnt : pkt_rx_q;
    pkt_seq_d    = arb_take ? seq_all[gnt] : pkt_seq_q;
    v1_d = rd_en;
    l1_d = rd_en && cnt_last;
    bv_d = v1_q;
    bl_d = l1_q;
    bo_d = fifo_q[pkt_rx_q];
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      last_grant_q <= RX_W'(NR - 1);
      pkt_rx_q     <= '0;
      pkt_seq_q    <= '0;
      cnt_q        <= '0;
      drain_q      <= 1'b0;
      v1_q         <= 1'b0;
      l1_q         <= 1'b0;
      bv_q         <= 1'b0;
      bl_q         <= 1'b0;
      bo_q         <= '0;
    end else begin
      last_grant_q <= last_grant_d;
      pkt_rx_q     <= pkt_rx_d;
      pkt_seq_q    <= pkt_seq_d;
      cnt_q        <= cnt_d;
      drain_q      <= drain_d;
      v1_q         <= v1_d;
      l1_q         <= l1_d;
      bv_q         <= bv_d;
      bl_q         <= bl_d;
      bo_q         <= bo_d;
    end
  end

  assign pkt_rx     = pkt_rx_q;
  assign pkt_seq    = pkt_seq_q;
  assign byte_out   = bo_q;
  assign byte_valid = bv_q;
  assign byte_last  = bl_q;

endmodule
